u_ifu_fetchctrl: RTL

- IFU fetch controller. Feeds the IDU instruction buffer over the double-fetch interface: fetch_vld, two insts, two PCs, two unalign flags.
- Holds the fetch PC and issues aligned pair requests to a fixed 1-cycle-latency instruction memory.
- Honours instBuffer backpressure and handles sync start, BRU redirect and exception/WFI halt.

---
 rtl/u_ifu_fetchctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/u_ifu_fetchctrl.sv
// IFU fetch controller: issues aligned pair requests to a 1-cycle imem and feeds the IDU double-fetch port.
// Optional feature macro IFU_FETCH_HOLD_BUF_EN adds a one-pair hold buffer for back-to-back issue.
`timescale 1ns/1ps
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module u_ifu_fetchctrl #(
  parameter int unsigned PC_W   = `PC_WIDTH,
  parameter int unsigned INST_W = `INST_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sync_start_pulse,
  input  logic [PC_W-1:0]     boot_pc,
  input  logic                bru_flush,
  input  logic [PC_W-1:0]     bru_redirect_pc,
  input  logic                dispatcher_detect_exceptions_wfi,
  input  logic                idu_ifu_instBuffer_full,
  output logic                imem_req_vld,
  output logic [PC_W-1:0]     imem_req_addr,
  input  logic                imem_rsp_vld,
  input  logic [2*INST_W-1:0] imem_rsp_data,
  output logic                ifu_idu_fetch_vld,
  output logic [INST_W-1:0]   ifu_idu_inst_0,
  output logic [INST_W-1:0]   ifu_idu_inst_1,
  output logic [PC_W-1:0]     ifu_idu_pc_0,
  output logic [PC_W-1:0]     ifu_idu_pc_1,
  output logic                ifu_idu_unalign_pc_0,
  output logic                ifu_idu_unalign_pc_1,
  output logic [1:0]          ifu_fetch_state
);

  localparam int unsigned PAIR_W = 2 * INST_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]   inflight_pc_q, inflight_pc_d;
  logic              inflight_vld_q, inflight_vld_d;

  logic              full;
  logic              run_ok;
  logic              rsp_pending;
  logic              issue;
  logic              fetch_vld_c;
  logic [PC_W-1:0]   out_pc_c;
  logic [PC_W-1:0]   out_pc1_c;
  logic [PAIR_W-1:0] out_data_c;

  assign full        = idu_ifu_instBuffer_full;
  // Any event cycle blocks both issue and delivery while the buffer resets its pointers.
  assign run_ok      = (state_q == ST_RUN) && !sync_start_pulse &&
                       !dispatcher_detect_exceptions_wfi && !bru_flush;
  assign rsp_pending = inflight_vld_q && imem_rsp_vld;

`ifdef IFU_FETCH_HOLD_BUF_EN
  logic              hold_vld_q;
  logic [PAIR_W-1:0] hold_data_q;
  logic [PC_W-1:0]   hold_pc_q;
  logic              deliver_hold;
  logic              deliver_live;
  logic              hold_load;

  assign issue        = run_ok && !(hold_vld_q && full) && !(rsp_pending && full);
  assign deliver_hold = run_ok && hold_vld_q && !full;
  assign deliver_live = run_ok && rsp_pending && !full && !hold_vld_q;
  assign hold_load    = run_ok && rsp_pending && (full || hold_vld_q);
  assign fetch_vld_c  = deliver_hold || deliver_live;
  assign out_pc_c     = hold_vld_q ? hold_pc_q : inflight_pc_q;
  assign out_data_c   = hold_vld_q ? hold_data_q : imem_rsp_data;

  // Hold buffer: parks a returned pair while the instruction buffer is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      hold_pc_q   <= '0;
    end else if (!run_ok) begin
      hold_vld_q  <= 1'b0;
    end else if (hold_load) begin
      hold_vld_q  <= 1'b1;
      hold_data_q <= imem_rsp_data;
      hold_pc_q   <= inflight_pc_q;
    end else if (deliver_hold) begin
      hold_vld_q  <= 1'b0;
    end
  end
`else
  // Single outstanding request; the buffer slots were reserved when it issued.
  assign issue       = run_ok && !inflight_vld_q && !full;
  assign fetch_vld_c = run_ok && rsp_pending;
  assign out_pc_c    = inflight_pc_q;
  assign out_data_c  = imem_rsp_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      fetch_pc_q     <= '0;
      inflight_pc_q  <= '0;
      inflight_vld_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      inflight_pc_q  <= inflight_pc_d;
      inflight_vld_q <= inflight_vld_d;
    end
  end

  // Next state and fetch PC, in event priority order.
  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    inflight_pc_d  = inflight_pc_q;
    inflight_vld_d = issue;
    if (sync_start_pulse) begin
      state_d    = ST_RUN;
      fetch_pc_d = boot_pc;
    end else if (state_q == ST_RUN) begin
      if (dispatcher_detect_exceptions_wfi) begin
        state_d = ST_HALT;
      end else if (bru_flush) begin
        fetch_pc_d = bru_redirect_pc;
      end else if (issue) begin
        fetch_pc_d    = fetch_pc_q + PC_W'(8);
        inflight_pc_d = fetch_pc_q;
      end
    end
  end

  assign out_pc1_c = out_pc_c + PC_W'(4);

  assign imem_req_vld         = issue;
  assign imem_req_addr        = issue ? {fetch_pc_q[PC_W-1:2], 2'b00} : '0;
  assign ifu_idu_fetch_vld    = fetch_vld_c;
  assign ifu_idu_inst_0       = fetch_vld_c ? out_data_c[INST_W-1:0] : '0;
  assign ifu_idu_inst_1       = fetch_vld_c ? out_data_c[PAIR_W-1:INST_W] : '0;
  assign ifu_idu_pc_0         = fetch_vld_c ? out_pc_c : '0;
  assign ifu_idu_pc_1         = fetch_vld_c ? out_pc1_c : '0;
  assign ifu_idu_unalign_pc_0 = fetch_vld_c && (|out_pc_c[1:0]);
  assign ifu_idu_unalign_pc_1 = fetch_vld_c && (|out_pc1_c[1:0]);
  assign ifu_fetch_state      = state_q;

endmodule
